// File: rtl/scroll_pkg.sv
`default_nettype none
// ============================================================================
// Module   : scroll_pkg
// Brief    : Shared types and constants for the scrolling-display fetch path.
// Revision : 1.0
// ============================================================================
package scroll_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    CAP  = 2'd2
  } scroll_state_t;

  localparam int DIGIT_W = 4;

endpackage
`default_nettype wire

// File: rtl/tick_gen.sv
`default_nettype none
// ============================================================================
// Module   : tick_gen
// Brief    : Scroll-rate prescaler; one-cycle tick every TICK_DIV enabled cycles.
// Revision : 1.0
// ============================================================================
module tick_gen #(
  parameter int TICK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int             CNT_W   = $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);

  // The fetch FSM needs three cycles per step, so faster ticks would be lost.
  generate
    if (TICK_DIV < 3) begin : g_div_check
      $error("tick_gen: TICK_DIV must be >= 3");
    end
  endgenerate

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    tick  = 1'b0;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      if (cnt_q == CNT_MAX) begin
        cnt_d = '0;
        tick  = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/scroll_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : scroll_fetch_ctrl
// Brief    : Fetches message nibbles from BRAM port B and scrolls them into
//            an N-digit display window at the prescaled rate.
// Revision : 1.0
// ============================================================================
module scroll_fetch_ctrl
  import scroll_pkg::*;
#(
  parameter int ADDR_W   = 6,
  parameter int DATA_W   = DIGIT_W,
  parameter int DIGITS   = 8,
  parameter int TICK_DIV = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       run,
  input  logic                       clear,
  input  logic [ADDR_W-1:0]          msg_last,
  output logic                       rd_en,
  output logic [ADDR_W-1:0]          rd_addr,
  input  logic [DATA_W-1:0]          rd_data,
  output logic [DIGITS*DATA_W-1:0]   disp,
  output logic                       step,
  output logic                       wrap
);

  localparam int DISP_W = DIGITS * DATA_W;

  scroll_state_t     state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [DISP_W-1:0] disp_q, disp_d;
  logic              tick;

  tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_gen (
    .clk   (clk),
    .reset (reset),
    .en    (run),
    .clr   (clear),
    .tick  (tick)
  );

  // step/wrap are asserted during CAP; disp takes the new digit on the edge
  // that closes that cycle. clear overrides everything, including the capture.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    rd_addr_d = rd_addr_q;
    disp_d    = disp_q;
    rd_en     = 1'b0;
    step      = 1'b0;
    wrap      = 1'b0;
    if (clear) begin
      state_d   = IDLE;
      addr_d    = '0;
      rd_addr_d = '0;
      disp_d    = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (tick) begin
            state_d   = REQ;
            rd_addr_d = addr_q;
          end
        end
        REQ: begin
          rd_en   = 1'b1;
          state_d = CAP;
        end
        CAP: begin
          disp_d = {disp_q[DISP_W-DATA_W-1:0], rd_data};
          step   = 1'b1;
          if (addr_q >= msg_last) begin
            addr_d = '0;
            wrap   = 1'b1;
          end else begin
            addr_d = addr_q + ADDR_W'(1);
          end
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      rd_addr_q <= '0;
      disp_q    <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      rd_addr_q <= rd_addr_d;
      disp_q    <= disp_d;
    end
  end

  assign rd_addr = rd_addr_q;
  assign disp    = disp_q;

endmodule
`default_nettype wire
